// File: rtl/dc_fifo_pkg.sv
// Shared helpers for dc_fifo: binary/gray conversion used by the pointer synchronizers.
// Functions work on a 32-bit container; callers zero-extend in and truncate out.
package dc_fifo_pkg;

    localparam int GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended upper bits leave the low bits of the result unaffected.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// Pointer crossing: gray register fed with the next pointer value, two sync flops,
// then back to binary. Output equals the source pointer delayed by two cycles.
module ptr_sync
    import dc_fifo_pkg::*;
#(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] i_ptr_next,
    output logic [AW-1:0] o_ptr_sync
);

    logic [AW-1:0] r_gray;
    logic [AW-1:0] r_sync_p0;
    logic [AW-1:0] r_sync_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gray    <= '0;
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
        end else begin
            r_gray    <= AW'(bin2gray(GRAY_MAX_W'(i_ptr_next)));
            r_sync_p0 <= r_gray;
            r_sync_p1 <= r_sync_p0;
        end
    end

    assign o_ptr_sync = AW'(gray2bin(GRAY_MAX_W'(r_sync_p1)));

endmodule

// File: rtl/dc_fifo.sv
// Single-clock FIFO whose write-side and read-side status each see the opposite pointer
// only through a gray-coded two-flop synchronizer, matching a dual-clock FIFO's behaviour.
module dc_fifo
    import dc_fifo_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          write,
    input  logic          read,
    output logic [DW-1:0] dout,
    output logic [AW-1:0] w_wr_cnt,
    output logic [AW-1:0] w_rd_cnt,
    output logic [AW-1:0] w_data_cnt,
    output logic          w_full,
    output logic          w_empty,
    output logic [AW-1:0] r_wr_cnt,
    output logic [AW-1:0] r_rd_cnt,
    output logic [AW-1:0] r_data_cnt,
    output logic          r_full,
    output logic          r_empty
);

    localparam int            DEPTH    = 1 << AW;
    localparam logic [AW-1:0] CNT_FULL = AW'(DEPTH - 1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [DW-1:0] r_dout;

    logic          w_wr_en;
    logic          w_rd_en;
    logic [AW-1:0] w_wr_next;
    logic [AW-1:0] w_rd_next;

    // Acceptance uses only the local side's pessimistic flag.
    assign w_wr_en   = write & ~w_full;
    assign w_rd_en   = read & ~r_empty;
    assign w_wr_next = w_wr_en ? r_wr_ptr + AW'(1) : r_wr_ptr;
    assign w_rd_next = w_rd_en ? r_rd_ptr + AW'(1) : r_rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
        end else if (w_rd_en) begin
            r_dout <= r_mem[r_rd_ptr];
        end
    end

    ptr_sync #(.AW(AW)) u_wr_sync (
        .clk        (clk),
        .rst        (rst),
        .i_ptr_next (w_wr_next),
        .o_ptr_sync (r_wr_cnt)
    );

    ptr_sync #(.AW(AW)) u_rd_sync (
        .clk        (clk),
        .rst        (rst),
        .i_ptr_next (w_rd_next),
        .o_ptr_sync (w_rd_cnt)
    );

    assign dout       = r_dout;
    assign w_wr_cnt   = r_wr_ptr;
    assign r_rd_cnt   = r_rd_ptr;
    assign w_data_cnt = w_wr_cnt - w_rd_cnt;
    assign r_data_cnt = r_wr_cnt - r_rd_cnt;
    assign w_full     = (w_data_cnt == CNT_FULL);
    assign w_empty    = (w_data_cnt == '0);
    assign r_full     = (r_data_cnt == CNT_FULL);
    assign r_empty    = (r_data_cnt == '0);

endmodule

// File: tb/tb_dc_fifo.sv
// Bench for dc_fifo: directed scenarios plus random traffic, every cycle checked
// against a queue-based reference with two-cycle delayed pointer views.
module tb_dc_fifo;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din;
    logic          wr;
    logic          rd;
    logic [DW-1:0] dout;
    logic [AW-1:0] w_wr_cnt, w_rd_cnt, w_data_cnt;
    logic [AW-1:0] r_wr_cnt, r_rd_cnt, r_data_cnt;
    logic          w_full, w_empty, r_full, r_empty;

    dc_fifo #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .write      (wr),
        .read       (rd),
        .dout       (dout),
        .w_wr_cnt   (w_wr_cnt),
        .w_rd_cnt   (w_rd_cnt),
        .w_data_cnt (w_data_cnt),
        .w_full     (w_full),
        .w_empty    (w_empty),
        .r_wr_cnt   (r_wr_cnt),
        .r_rd_cnt   (r_rd_cnt),
        .r_data_cnt (r_data_cnt),
        .r_full     (r_full),
        .r_empty    (r_empty)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: local pointers as integers, what each was one and two cycles ago,
    // and the stored words in arrival order.
    int            m_wr, m_rd;
    int            m_wh0, m_wh1, m_rh0, m_rh1;
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_dout;

    function automatic int mcnt(input int a, input int b);
        return (a - b + DEPTH) % DEPTH;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int wdc, rdc;
        wdc = mcnt(m_wr, m_rh1);
        rdc = mcnt(m_wh1, m_rd);
        chk("w_wr_cnt",   32'(w_wr_cnt),   32'(m_wr));
        chk("w_rd_cnt",   32'(w_rd_cnt),   32'(m_rh1));
        chk("w_data_cnt", 32'(w_data_cnt), 32'(wdc));
        chk("w_full",     32'(w_full),     32'(wdc == DEPTH - 1));
        chk("w_empty",    32'(w_empty),    32'(wdc == 0));
        chk("r_wr_cnt",   32'(r_wr_cnt),   32'(m_wh1));
        chk("r_rd_cnt",   32'(r_rd_cnt),   32'(m_rd));
        chk("r_data_cnt", 32'(r_data_cnt), 32'(rdc));
        chk("r_full",     32'(r_full),     32'(rdc == DEPTH - 1));
        chk("r_empty",    32'(r_empty),    32'(rdc == 0));
        chk("dout",       32'(dout),       32'(m_dout));
    endtask

    task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic rs);
        bit wf, re, wa, ra;
        wr  = w;
        rd  = r;
        din = d;
        rst = rs;
        @(posedge clk);
        if (rs) begin
            m_wr = 0; m_rd = 0;
            m_wh0 = 0; m_wh1 = 0; m_rh0 = 0; m_rh1 = 0;
            m_q.delete();
            m_dout = '0;
        end else begin
            wf = (mcnt(m_wr, m_rh1) == DEPTH - 1);
            re = (mcnt(m_wh1, m_rd) == 0);
            wa = w && !wf;
            ra = r && !re;
            if (ra && m_q.size() > 0) m_dout = m_q.pop_front();
            if (wa) m_q.push_back(d);
            m_wh1 = m_wh0; m_wh0 = m_wr;
            m_rh1 = m_rh0; m_rh0 = m_rd;
            m_wr  = (m_wr + int'(wa)) % DEPTH;
            m_rd  = (m_rd + int'(ra)) % DEPTH;
        end
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        int acc;
        bit g;
        wr = 0; rd = 0; din = '0; rst = 1;
        m_wr = 0; m_rd = 0; m_wh0 = 0; m_wh1 = 0; m_rh0 = 0; m_rh1 = 0; m_dout = '0;

        // Reset state
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("rst_w_empty", 32'(w_empty), 32'd1);
        chk("rst_r_empty", 32'(r_empty), 32'd1);
        chk("rst_dout",    32'(dout),    32'd0);

        // Fill: ten gated writes, seven accepted
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            g = !w_full;
            acc += int'(g);
            step(g, 1'b0, 8'($urandom), 1'b0);
        end
        chk("fill_accepted", 32'(acc),        32'd7);
        chk("fill_w_full",   32'(w_full),     32'd1);
        chk("fill_w_cnt",    32'(w_data_cnt), 32'd7);
        idle(2);
        chk("fill_r_cnt",    32'(r_data_cnt), 32'd7);

        // Drain: ten gated reads, seven accepted; w_full drops on the third cycle
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            g = !r_empty;
            acc += int'(g);
            step(1'b0, g, '0, 1'b0);
            if (i < 2) chk("drain_w_full_held", 32'(w_full), 32'd1);
            if (i == 2) chk("drain_w_full_drop", 32'(w_full), 32'd0);
        end
        chk("drain_accepted", 32'(acc),     32'd7);
        chk("drain_r_empty",  32'(r_empty), 32'd1);
        idle(3);

        // Wrap: write 5 / read 5, twice
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 5; i++) step(!w_full, 1'b0, 8'($urandom), 1'b0);
            chk("wrap_w_wr_cnt", 32'(w_wr_cnt), (rep == 0) ? 32'd4 : 32'd1);
            idle(2);
            for (int i = 0; i < 5; i++) step(1'b0, !r_empty, '0, 1'b0);
            idle(2);
            chk("wrap_w_empty", 32'(w_empty), 32'd1);
            chk("wrap_r_empty", 32'(r_empty), 32'd1);
        end

        // Simultaneous read and write at a count of 3
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
        idle(2);
        chk("sim_r_cnt_start", 32'(r_data_cnt), 32'd3);
        for (int i = 0; i < 4; i++) step(1'b1, !r_empty, 8'($urandom), 1'b0);
        idle(2);
        chk("sim_r_cnt_end", 32'(r_data_cnt), 32'd3);
        chk("sim_w_cnt_end", 32'(w_data_cnt), 32'd3);
        for (int i = 0; i < 8; i++) step(1'b0, !r_empty, '0, 1'b0);
        idle(2);

        // Reset with five stored words; old data must never reappear
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
        idle(2);
        step(1'b0, 1'b1, '0, 1'b1);
        chk("mid_rst_w_cnt",   32'(w_data_cnt), 32'd0);
        chk("mid_rst_r_empty", 32'(r_empty),    32'd1);
        chk("mid_rst_dout",    32'(dout),       32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, 1'b0);
        chk("post_rst_dout",   32'(dout),       32'd0);
        step(1'b1, 1'b0, 8'hA5, 1'b0);
        idle(2);
        step(1'b0, 1'b1, '0, 1'b0);
        chk("post_rst_word",   32'(dout),       32'hA5);
        idle(2);

        // Random traffic, write-heavy then read-heavy, ungated strobes
        for (int i = 0; i < 400; i++) begin
            if (i < 200)
                step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 8'($urandom), 1'b0);
            else
                step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, 8'($urandom), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
